div_seq_ctrl: RTL and testbench
===============================

Name: div_seq_ctrl

Overview:
- Control sequencer for the execute-stage iterative shift-subtract divider (div/divu/mod/modu).
- Accepts one divide request from EX and drives per-cycle load/step/fixup strobes into the divider datapath. Counts iterations, holds EX until the result can move to MEM, and aborts cleanly on pipeline flush.
- Sole owner of divider sequencing. The datapath holds the operand, partial-remainder and quotient registers only.

Parameters:
- WIDTH, 32, operand width; the number of step cycles equals WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  core clock
- resetn  input  1  asynchronous, active-low reset
- req_valid  input  1  EX holds a valid divide op (es_valid & is_div)
- req_signed  input  1  signed op (div/mod)
- req_quot  input  1  1 = quotient result (div/divu), 0 = remainder (mod/modu)
- x_neg  input  1  dividend sign bit; sampled at accept, ignored unless req_signed
- y_neg  input  1  divisor sign bit; sampled at accept, ignored unless req_signed
- y_zero  input  1  divisor == 0, sampled at accept
- flush  input  1  pipeline flush (exception/ertn); kills the in-flight divide
- ms_allowin  input  1  MEM stage can accept
- dp_load  output  1  datapath loads |x|, |y|, clears partial remainder
- dp_step  output  1  datapath performs one shift-subtract iteration
- dp_fix  output  1  datapath applies sign correction this cycle
- dp_neg_q  output  1  negate quotient during fix
- dp_neg_r  output  1  negate remainder during fix
- res_sel_quot  output  1  latched req_quot, for the result mux
- div_zero  output  1  latched y_zero; the result is architecturally undefined, and the datapath outputs quotient all-ones and remainder x
- busy  output  1  FSM not IDLE
- res_valid  output  1  result stable on datapath outputs
- es_go  output  1  EX may advance the divide instruction
- iter_cnt  output  CNT_W  completed step count (debug/coverage)

Behaviour:
- Reset (async assert, sync deassert via resetn): state IDLE; iter_cnt=0; all latched flags 0; all outputs 0.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - Accept when req_valid & ~flush.
  - On accept: dp_load=1 that cycle; latch signed, quot, x_neg, y_neg, y_zero.
  - Next state is RUN, or DONE if y_zero.
- RUN:
  - dp_step=1 every cycle; iter_cnt increments.
  - When iter_cnt == WIDTH-1 in the current cycle, next state is FIX (exactly WIDTH step pulses).
- FIX:
  - dp_fix=1 for one cycle.
  - dp_neg_q = signed & (x_neg ^ y_neg).
  - dp_neg_r = signed & x_neg.
  - Next state is DONE.
- DONE:
  - res_valid=1.
  - es_go = ms_allowin.
  - When es_go=1, go to IDLE and clear iter_cnt.
  - Otherwise hold DONE with the result stable.
- Latency (normal): accept at cycle T0; dp_step T1..T32; dp_fix T33; res_valid from T34; earliest es_go T34 (35 cycles).
- Latency (y_zero): res_valid and earliest es_go at T1.
- es_go is 0 in every state other than DONE, so EX stalls for the whole operation.
- Flush:
  - Any state returns to IDLE on the next edge, with iter_cnt=0 and no res_valid or es_go.
  - Flush overrides accept in IDLE and overrides es_go in DONE; es_go is gated by ~flush.
- req_valid is ignored while busy; the request is held by EX stall, never queued.
- A back-to-back divide is accepted in the cycle after the DONE→IDLE transition, never in the same cycle as es_go.
- res_sel_quot and div_zero stay stable from accept until the return to IDLE.
- Outputs are pure functions of state and latched flags, with two exceptions: dp_load depends combinationally on req_valid/flush, and es_go depends combinationally on ms_allowin/flush.

Decomposition:
- Shared package (cpu_pkg): state encoding constants DIV_IDLE/RUN/FIX/DONE (2-bit), DIV_WIDTH=32, DIV_CNT_W=6.
- No sub-module: single FSM plus counter plus flag registers. The datapath is the separate divider module and is instantiated beside this block by the ALU.

Test Plan:
- Unsigned 100/7, quot, ms_allowin=1 → dp_step 32 pulses T1–T32; dp_fix at T33 with neg_q=neg_r=0; es_go at T34; iter_cnt reaches 32.
- Signed -100/7, mod → dp_neg_q=1, dp_neg_r=1 at FIX; res_sel_quot=0. Signed 100/-7 div → neg_q=1, neg_r=0.
- y_zero: divu x=5, y=0 → no dp_step pulses; div_zero=1; res_valid and es_go at T1.
- ms_allowin held 0 for 10 cycles after T34 → DONE held, res_valid=1, es_go=0; es_go pulses on the first cycle ms_allowin=1; IDLE next.
- flush at T10 (RUN) → IDLE at T11, iter_cnt=0, no dp_fix and no es_go. A new req_valid at T11 is accepted, and its es_go lands at T45.
- Async reset: drive resetn low mid-RUN, asynchronously → busy=0 and iter_cnt=0 immediately, without waiting for a clock edge. No outputs assert after resetn releases until a new accept.

Source files
------------

// File: rtl/div_seq_ctrl_pkg.sv
// Shared definitions for the iterative divider control sequencer:
// state encoding, default sizing and the latched request flags.
package div_seq_ctrl_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

    // Request attributes captured at accept and held until the op retires.
    typedef struct packed {
        logic sgn;
        logic quot;
        logic x_neg;
        logic y_neg;
        logic y_zero;
    } div_flags_t;

    localparam div_flags_t DIV_FLAGS_CLR = div_flags_t'(5'b0_0000);

    // Quotient is negative when exactly one signed operand is negative.
    function automatic logic div_neg_q(input div_flags_t f);
        return f.sgn & (f.x_neg ^ f.y_neg);
    endfunction

    // Remainder takes the sign of the dividend.
    function automatic logic div_neg_r(input div_flags_t f);
        return f.sgn & f.x_neg;
    endfunction

endpackage

// File: rtl/div_seq_ctrl.sv
// Control sequencer for the execute-stage shift-subtract divider.
// Accepts one request, issues load / WIDTH steps / sign-fix strobes to the
// datapath, then holds the result until MEM accepts it. Flush aborts any op.
module div_seq_ctrl
    import div_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    input  logic             req_signed,
    input  logic             req_quot,
    input  logic             x_neg,
    input  logic             y_neg,
    input  logic             y_zero,
    input  logic             flush,
    input  logic             ms_allowin,
    output logic             dp_load,
    output logic             dp_step,
    output logic             dp_fix,
    output logic             dp_neg_q,
    output logic             dp_neg_r,
    output logic             res_sel_quot,
    output logic             div_zero,
    output logic             busy,
    output logic             res_valid,
    output logic             es_go,
    output logic [CNT_W-1:0] iter_cnt
);

    // Counter value seen in the cycle of the final step.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    div_flags_t       flags_q, flags_d;

    // State, iteration counter and latched request flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= DIV_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            flags_q <= DIV_FLAGS_CLR;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
        end
    end

    // Next-state logic and per-state strobes; flush wins over everything.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        flags_d   = flags_q;
        dp_load   = 1'b0;
        dp_step   = 1'b0;
        dp_fix    = 1'b0;
        dp_neg_q  = 1'b0;
        dp_neg_r  = 1'b0;
        res_valid = 1'b0;
        es_go     = 1'b0;

        case (state_q)
            DIV_IDLE: begin
                if (req_valid && !flush) begin
                    dp_load        = 1'b1;
                    flags_d.sgn    = req_signed;
                    flags_d.quot   = req_quot;
                    flags_d.x_neg  = x_neg;
                    flags_d.y_neg  = y_neg;
                    flags_d.y_zero = y_zero;
                    cnt_d          = {CNT_W{1'b0}};
                    // Divide by zero skips iteration; datapath supplies fixed result.
                    state_d        = y_zero ? DIV_DONE : DIV_RUN;
                end else begin
                    state_d = DIV_IDLE;
                end
            end
            DIV_RUN: begin
                dp_step = 1'b1;
                cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == LAST_CNT) begin
                    state_d = DIV_FIX;
                end else begin
                    state_d = DIV_RUN;
                end
            end
            DIV_FIX: begin
                dp_fix   = 1'b1;
                dp_neg_q = div_neg_q(flags_q);
                dp_neg_r = div_neg_r(flags_q);
                state_d  = DIV_DONE;
            end
            DIV_DONE: begin
                res_valid = 1'b1;
                es_go     = ms_allowin & ~flush;
                if (es_go) begin
                    state_d = DIV_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                    flags_d = DIV_FLAGS_CLR;
                end else begin
                    state_d = DIV_DONE;
                end
            end
            default: begin
                state_d = DIV_IDLE;
                cnt_d   = {CNT_W{1'b0}};
                flags_d = DIV_FLAGS_CLR;
            end
        endcase

        if (flush) begin
            state_d = DIV_IDLE;
            cnt_d   = {CNT_W{1'b0}};
            flags_d = DIV_FLAGS_CLR;
        end else begin
            state_d = state_d;
        end
    end

    // Status outputs derived straight from registered state.
    always_comb begin
        busy         = (state_q != DIV_IDLE);
        res_sel_quot = flags_q.quot;
        div_zero     = flags_q.y_zero;
        iter_cnt     = cnt_q;
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: table of complete operations plus
// hand-written sequences for stall, flush and asynchronous reset.
module tb_div_seq_ctrl;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_signed = 1'b0;
    logic             req_quot = 1'b0;
    logic             x_neg = 1'b0;
    logic             y_neg = 1'b0;
    logic             y_zero = 1'b0;
    logic             flush = 1'b0;
    logic             ms_allowin = 1'b0;
    logic             dp_load, dp_step, dp_fix, dp_neg_q, dp_neg_r;
    logic             res_sel_quot, div_zero, busy, res_valid, es_go;
    logic [CNT_W-1:0] iter_cnt;

    int n_vec = 0;
    int n_bad = 0;

    div_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_signed(req_signed),
        .req_quot(req_quot), .x_neg(x_neg), .y_neg(y_neg), .y_zero(y_zero),
        .flush(flush), .ms_allowin(ms_allowin), .dp_load(dp_load), .dp_step(dp_step),
        .dp_fix(dp_fix), .dp_neg_q(dp_neg_q), .dp_neg_r(dp_neg_r),
        .res_sel_quot(res_sel_quot), .div_zero(div_zero), .busy(busy),
        .res_valid(res_valid), .es_go(es_go), .iter_cnt(iter_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        logic  s, q, xn, yn, z;
        int    e_steps;
        int    e_fix;
        logic  e_nq, e_nr;
        int    e_go;
        int    e_iter;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    // Runs from cycle 1 after an accept until es_go (or budget expiry).
    task automatic run_op(input int budget, output int steps, output int fix_c,
                          output int go_c, output int loads, output logic nq,
                          output logic nr, output logic rq, output logic dz,
                          output logic rv, output int it_go);
        steps = 0; fix_c = -1; go_c = -1; loads = 0;
        nq = 1'b0; nr = 1'b0; rq = 1'b0; dz = 1'b0; rv = 1'b0; it_go = -1;
        for (int t = 1; t <= budget; t++) begin
            @(negedge clk);
            if (dp_step) steps++;
            if (dp_load) loads++;
            if (dp_fix) begin
                fix_c = t; nq = dp_neg_q; nr = dp_neg_r;
            end
            if (es_go) begin
                go_c = t; rq = res_sel_quot; dz = div_zero; rv = res_valid;
                it_go = int'(iter_cnt);
            end
            step_clk();
            if (go_c >= 0) break;
        end
    endtask

    task automatic set_req(input logic s, input logic q, input logic xn,
                           input logic yn, input logic z);
        req_valid = 1'b1; req_signed = s; req_quot = q;
        x_neg = xn; y_neg = yn; y_zero = z;
    endtask

    vec_t vecs[7];
    int   steps, fix_c, go_c, loads, it_go, cnt;
    logic nq, nr, rq, dz, rv;

    initial begin
        vecs[0] = '{"divu_100_7",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32, 33, 1'b0, 1'b0, 34, 32};
        vecs[1] = '{"mod_m100_7",   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32, 33, 1'b1, 1'b1, 34, 32};
        vecs[2] = '{"div_100_m7",   1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32, 33, 1'b1, 1'b0, 34, 32};
        vecs[3] = '{"div_m100_m7",  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32, 33, 1'b0, 1'b1, 34, 32};
        vecs[4] = '{"modu_bigbits", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32, 33, 1'b0, 1'b0, 34, 32};
        vecs[5] = '{"divu_5_0",     1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, -1, 1'b0, 1'b0, 1, 0};
        vecs[6] = '{"mod_m5_0",     1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, -1, 1'b0, 1'b0, 1, 0};

        // Reset state.
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_outs", {dp_load, dp_step, dp_fix, dp_neg_q, dp_neg_r, res_sel_quot,
                         div_zero, res_valid, es_go}, 9'd0);
        chk("rst_iter", iter_cnt, 0);
        @(negedge clk);
        resetn = 1'b1;
        step_clk();

        // Table of complete operations; request fields flip after accept
        // to prove they are latched, and req_valid stays high while busy.
        for (int i = 0; i < 7; i++) begin
            set_req(vecs[i].s, vecs[i].q, vecs[i].xn, vecs[i].yn, vecs[i].z);
            ms_allowin = 1'b1;
            @(negedge clk);
            chk({vecs[i].name, "_load"}, dp_load, 1'b1);
            step_clk();
            req_signed = ~req_signed; req_quot = ~req_quot;
            x_neg = ~x_neg; y_neg = ~y_neg; y_zero = ~y_zero;
            run_op(100, steps, fix_c, go_c, loads, nq, nr, rq, dz, rv, it_go);
            req_valid = 1'b0;
            chk({vecs[i].name, "_steps"}, steps, vecs[i].e_steps);
            chk({vecs[i].name, "_fixcyc"}, fix_c, vecs[i].e_fix);
            chk({vecs[i].name, "_negq"}, nq, vecs[i].e_nq);
            chk({vecs[i].name, "_negr"}, nr, vecs[i].e_nr);
            chk({vecs[i].name, "_gocyc"}, go_c, vecs[i].e_go);
            chk({vecs[i].name, "_resval"}, rv, 1'b1);
            chk({vecs[i].name, "_quot"}, rq, vecs[i].q);
            chk({vecs[i].name, "_zero"}, dz, vecs[i].z);
            chk({vecs[i].name, "_iter"}, it_go, vecs[i].e_iter);
            chk({vecs[i].name, "_noreload"}, loads, 0);
            @(negedge clk);
            chk({vecs[i].name, "_idle"}, {busy, res_valid, es_go}, 3'b000);
            step_clk();
        end

        // MEM stall: result held in DONE until ms_allowin rises.
        set_req(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ms_allowin = 1'b0;
        step_clk();
        req_valid = 1'b0;
        for (int t = 1; t < 34; t++) step_clk();
        for (int t = 34; t < 44; t++) begin
            @(negedge clk);
            chk("stall_hold", {busy, res_valid, es_go}, 3'b110);
            step_clk();
        end
        ms_allowin = 1'b1;
        @(negedge clk);
        chk("stall_go", {res_valid, es_go, iter_cnt}, {2'b11, 6'd32});
        step_clk();
        @(negedge clk);
        chk("stall_idle", busy, 1'b0);
        step_clk();

        // Flush during RUN at T10, new accept at T11, its es_go at T45.
        set_req(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step_clk();
        cnt = 0;
        for (int t = 1; t <= 10; t++) begin
            if (t == 10) flush = 1'b1;
            @(negedge clk);
            if (dp_fix || es_go) cnt++;
            if (t == 10) chk("flush_iter9", iter_cnt, 9);
            step_clk();
        end
        flush = 1'b0;
        chk("flush_nofix_nogo", cnt, 0);
        chk("flush_idle", {busy, iter_cnt}, 7'd0);
        @(negedge clk);
        chk("flush_reaccept", dp_load, 1'b1);
        step_clk();
        req_valid = 1'b0;
        run_op(100, steps, fix_c, go_c, loads, nq, nr, rq, dz, rv, it_go);
        chk("flush_go_T45", go_c + 11, 45);
        chk("flush_steps", steps, 32);

        // Flush beats accept in IDLE.
        set_req(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        chk("idle_flush_noload", dp_load, 1'b0);
        step_clk();
        req_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("idle_flush_notbusy", busy, 1'b0);
        step_clk();

        // Flush beats es_go in DONE.
        set_req(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        ms_allowin = 1'b1;
        step_clk();
        req_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        chk("done_flush_nogo", {res_valid, es_go}, 2'b10);
        step_clk();
        flush = 1'b0;
        @(negedge clk);
        chk("done_flush_idle", {busy, res_valid, div_zero}, 3'b000);
        step_clk();

        // Asynchronous reset in the middle of RUN.
        set_req(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step_clk();
        req_valid = 1'b0;
        for (int t = 1; t <= 5; t++) step_clk();
        chk("arst_pre_busy", {busy, iter_cnt}, {1'b1, 6'd5});
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_iter", iter_cnt, 0);
        chk("arst_step", dp_step, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        for (int t = 0; t < 5; t++) begin
            step_clk();
            @(negedge clk);
            chk("arst_quiet", {dp_load, dp_step, dp_fix, res_valid, es_go, busy}, 6'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
